// File: rtl/propellant_budget_if.sv
// Request/result bundle for the propellant budget calculator.
// Request: start, dv (m/s x1000), ve (m/s x1000), m0 (grams); master drives these.
// Result: busy, done, err, mu_ppm (mf/m0 x1e6), mf, mp (grams); the calculator drives these.
interface propellant_budget_if;
   logic        start;
   logic [31:0] dv;
   logic [31:0] ve;
   logic [39:0] m0;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] mu_ppm;
   logic [39:0] mf;
   logic [39:0] mp;

   modport master (output start, dv, ve, m0,
                   input  busy, done, err, mu_ppm, mf, mp);
   modport slave  (input  start, dv, ve, m0,
                   output busy, done, err, mu_ppm, mf, mp);
endinterface

// File: rtl/propellant_budget.sv
// Propellant budget: mu = exp(-dv/ve), mf = m0*mu, mp = m0-mf, all unsigned fixed point.
// Latency: accept -> done = 1 + 27 + Nterms + 25 + 1 + 1 cycles (max 79); 2 cycles on err.
// Backpressure: none; start is taken only in IDLE and ignored while a job is in flight.
// Ports: clk, reset (sync, active-high), bus (slave modport of propellant_budget_if).
module propellant_budget #(
   parameter int FRAC      = 24,
   parameter int MAX_TERMS = 24,
   parameter int XMAX      = 8
) (
   input  logic               clk,
   input  logic               reset,
   propellant_budget_if.slave bus
);
   localparam int XB   = $clog2(XMAX);          // integer bits of x
   localparam int XW   = FRAC + XB;             // x width = DIVX cycle count
   localparam int SW   = FRAC + 12;             // term / sum width
   localparam int RW   = SW + 1;                // divider partial remainder width
   localparam int MUW  = FRAC + 1;              // mu width = DIVMU cycle count
   localparam int NW   = $clog2(MAX_TERMS + 1);
   localparam int CW   = $clog2(XW + 1);
   localparam int PW   = SW + XW;               // term * x
   localparam int TXW  = PW - FRAC;             // (term * x) >> FRAC
   localparam int TRW  = TXW + MUW;             // ... * RECIP[n]
   localparam int MFW  = 40 + MUW;              // m0 * mu
   localparam int PPW  = MUW + 21;              // mu * 1e6 + half
   localparam logic [SW-1:0] ONE = SW'(1) << FRAC;

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIVX, S_EXP, S_DIVMU, S_OUT, S_FIN} state_t;

   state_t          state_q;
   logic [31:0]     dv_q, ve_q;
   logic [39:0]     m0_q;
   logic [RW-1:0]   rem_q;
   logic [SW-1:0]   dsr_q;      // divisor: ve during DIVX, sum during DIVMU
   logic [XW-1:0]   dlow_q;     // dividend bits still to be shifted in
   logic [XW-1:0]   quo_q;      // quotient; holds x throughout EXP, mu after DIVMU
   logic [CW-1:0]   cnt_q;
   logic [SW-1:0]   term_q, sum_q;
   logic [NW-1:0]   n_q;
   logic            busy_q, done_q, err_q;
   logic [31:0]     mu_ppm_q;
   logic [39:0]     mf_q, mp_q;

   // Reciprocal ROM: RECIP[n] = round(2^FRAC / n); entry 0 is never addressed.
   logic [MUW-1:0]  recip_rom [0:MAX_TERMS];
   for (genvar g = 0; g <= MAX_TERMS; g++) begin : g_recip
      if (g == 0) begin : g_zero
         assign recip_rom[g] = '0;
      end else begin : g_val
         assign recip_rom[g] = MUW'(((64'd1 << FRAC) + 64'(g / 2)) / 64'(g));
      end
   end

   // Shared restoring-divider step, one quotient bit per cycle, MSB first.
   logic [RW-1:0]   trial, rem_d;
   logic            fits;
   logic [XW-1:0]   quo_d;
   assign trial = {rem_q[RW-2:0], dlow_q[XW-1]};
   assign fits  = trial >= RW'(dsr_q);
   assign rem_d = fits ? trial - RW'(dsr_q) : trial;
   assign quo_d = {quo_q[XW-2:0], fits};

   // Taylor step: operands are widened first so truncation happens only at the shifts.
   logic [PW-1:0]   tx_prod;
   logic [TXW-1:0]  tx;
   logic [TRW-1:0]  tr_prod;
   logic [SW-1:0]   term_d, sum_d;
   assign tx_prod = PW'(term_q) * PW'(quo_q);
   assign tx      = TXW'(tx_prod >> FRAC);
   assign tr_prod = TRW'(tx) * TRW'(recip_rom[n_q]);
   assign term_d  = SW'(tr_prod >> FRAC);   // term < 2^12 for x < 8, upper bits are zero
   assign sum_d   = sum_q + term_d;

   // Output scaling.
   logic [MFW-1:0]  mf_prod;
   logic [PPW-1:0]  ppm_prod;
   logic [39:0]     mf_d, mp_d;
   logic [31:0]     mu_ppm_d;
   assign mf_prod  = MFW'(m0_q) * MFW'(quo_q[MUW-1:0]);
   assign mf_d     = 40'(mf_prod >> FRAC);  // mu <= 1.0 so mf <= m0
   assign mp_d     = m0_q - mf_d;
   assign ppm_prod = PPW'(quo_q[MUW-1:0]) * PPW'(1_000_000) + (PPW'(1) << (FRAC - 1));
   assign mu_ppm_d = 32'(ppm_prod >> FRAC);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         dv_q     <= '0;
         ve_q     <= '0;
         m0_q     <= '0;
         rem_q    <= '0;
         dsr_q    <= '0;
         dlow_q   <= '0;
         quo_q    <= '0;
         cnt_q    <= '0;
         term_q   <= '0;
         sum_q    <= '0;
         n_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         mu_ppm_q <= '0;
         mf_q     <= '0;
         mp_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  dv_q     <= bus.dv;
                  ve_q     <= bus.ve;
                  m0_q     <= bus.m0;
                  busy_q   <= 1'b1;
                  err_q    <= 1'b0;
                  mu_ppm_q <= '0;
                  mf_q     <= '0;
                  mp_q     <= '0;
                  state_q  <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (ve_q == '0 || {16'b0, dv_q} >= 48'(XMAX) * {16'b0, ve_q}) begin
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_FIN;
               end else begin
                  // dv < XMAX*ve guarantees the top remainder (dv >> XB) is already < ve,
                  // so only the XW low quotient bits need to be produced.
                  rem_q   <= RW'(dv_q >> XB);
                  dlow_q  <= {dv_q[XB-1:0], {FRAC{1'b0}}};
                  dsr_q   <= SW'(ve_q);
                  quo_q   <= '0;
                  cnt_q   <= CW'(XW - 1);
                  state_q <= S_DIVX;
               end
            end
            S_DIVX: begin
               rem_q  <= rem_d;
               quo_q  <= quo_d;
               dlow_q <= dlow_q << 1;
               if (cnt_q == '0) begin
                  term_q  <= ONE;
                  sum_q   <= ONE;
                  n_q     <= NW'(1);
                  state_q <= S_EXP;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_EXP: begin
               term_q <= term_d;
               sum_q  <= sum_d;
               n_q    <= n_q + NW'(1);
               if (term_d == '0 || n_q == NW'(MAX_TERMS)) begin
                  // 2^(2*FRAC) >> MUW = 2^(FRAC-1) < sum, and all remaining dividend bits are 0.
                  rem_q   <= RW'(1) << (FRAC - 1);
                  dsr_q   <= sum_d;
                  dlow_q  <= '0;
                  quo_q   <= '0;
                  cnt_q   <= CW'(MUW - 1);
                  state_q <= S_DIVMU;
               end
            end
            S_DIVMU: begin
               rem_q  <= rem_d;
               quo_q  <= quo_d;
               dlow_q <= dlow_q << 1;
               if (cnt_q == '0) begin
                  state_q <= S_OUT;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_OUT: begin
               mf_q     <= mf_d;
               mp_q     <= mp_d;
               mu_ppm_q <= mu_ppm_d;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= S_FIN;
            end
            S_FIN: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.err    = err_q;
   assign bus.mu_ppm = mu_ppm_q;
   assign bus.mf     = mf_q;
   assign bus.mp     = mp_q;
endmodule

// File: tb/tb_propellant_budget.sv
// Bench for propellant_budget: directed physics cases, error path, back-to-back and reset abort,
// plus randomized jobs compared against an arithmetic reference model.
module tb_propellant_budget;
   localparam int FRAC      = 24;
   localparam int MAX_TERMS = 24;
   localparam int XMAX      = 8;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

   propellant_budget_if bus ();

   propellant_budget #(.FRAC(FRAC), .MAX_TERMS(MAX_TERMS), .XMAX(XMAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model straight from the arithmetic rules; lat is cycles from accept to done.
   function automatic void model(input logic [31:0] dv, input logic [31:0] ve, input logic [39:0] m0,
                                 output logic err, output logic [31:0] ppm,
                                 output logic [39:0] mf, output logic [39:0] mp, output int lat);
      longint unsigned x, term, sum, mu, recip;
      logic [127:0]    big;
      int              nterms;
      if (ve == 0 || 64'(dv) >= 64'(XMAX) * 64'(ve)) begin
         err = 1'b1; ppm = 0; mf = 0; mp = 0; lat = 2;
         return;
      end
      err    = 1'b0;
      x      = (64'(dv) << FRAC) / 64'(ve);
      term   = 64'd1 << FRAC;
      sum    = term;
      nterms = 0;
      for (int k = 1; k <= MAX_TERMS; k++) begin
         recip  = ((64'd1 << FRAC) + 64'(k / 2)) / 64'(k);
         term   = (((term * x) >> FRAC) * recip) >> FRAC;
         sum    = sum + term;
         nterms = k;
         if (term == 0) break;
      end
      mu  = (64'd1 << (2 * FRAC)) / sum;
      big = 128'(m0) * 128'(mu);
      mf  = 40'(big >> FRAC);
      mp  = m0 - mf;
      ppm = 32'((mu * 64'd1_000_000 + (64'd1 << (FRAC - 1))) >> FRAC);
      lat = 1 + 27 + nterms + 25 + 1 + 1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launch one job from IDLE, wait (bounded) for done, capture results, then step one more cycle.
   task automatic do_job(input logic [31:0] dv, input logic [31:0] ve, input logic [39:0] m0,
                         output int lat, output logic busy_seen, output logic err,
                         output logic [31:0] ppm, output logic [39:0] mf, output logic [39:0] mp,
                         output logic done_next);
      bus.dv = dv; bus.ve = ve; bus.m0 = m0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      busy_seen = bus.busy;
      lat = 1;
      while (bus.done !== 1'b1 && lat < 200) begin
         step();
         lat++;
      end
      err = bus.err; ppm = bus.mu_ppm; mf = bus.mf; mp = bus.mp;
      step();
      done_next = bus.done;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b0; bus.dv = '0; bus.ve = '0; bus.m0 = '0;
      repeat (3) step();
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else n_pass++;
      n_checks++; if (bus.done !== 1'b0 || bus.err !== 1'b0) $display("FAIL reset_done_err: got %b%b expected 00", bus.done, bus.err); else n_pass++;
      n_checks++; if (bus.mu_ppm !== 0 || bus.mf !== 0 || bus.mp !== 0) $display("FAIL reset_outputs: got %0d/%0d/%0d expected 0/0/0", bus.mu_ppm, bus.mf, bus.mp); else n_pass++;
      reset = 1'b0;
      step();
   endtask

   task automatic test_identity();
      int lat, elat; logic bs, err, dn, eerr; logic [31:0] ppm, eppm; logic [39:0] mf, mp, emf, emp;
      model(32'd0, 32'd2_577_137, 40'd1_000_000, eerr, eppm, emf, emp, elat);
      do_job(32'd0, 32'd2_577_137, 40'd1_000_000, lat, bs, err, ppm, mf, mp, dn);
      n_checks++; if (bs !== 1'b1) $display("FAIL id_busy: got %b expected 1", bs); else n_pass++;
      n_checks++; if (err !== 1'b0) $display("FAIL id_err: got %b expected 0", err); else n_pass++;
      n_checks++; if (ppm !== 32'd1_000_000) $display("FAIL id_ppm: got %0d expected 1000000", ppm); else n_pass++;
      n_checks++; if (mf !== 40'd1_000_000 || mp !== 40'd0) $display("FAIL id_mass: got mf %0d mp %0d expected 1000000/0", mf, mp); else n_pass++;
      n_checks++; if (lat > 60 || lat != elat) $display("FAIL id_latency: got %0d expected %0d (<=60)", lat, elat); else n_pass++;
      n_checks++; if (dn !== 1'b0) $display("FAIL id_done_pulse: got %b expected 0", dn); else n_pass++;
      repeat (3) step();
      n_checks++; if (bus.mu_ppm !== eppm || bus.mf !== emf) $display("FAIL id_hold: got %0d/%0d expected %0d/%0d", bus.mu_ppm, bus.mf, eppm, emf); else n_pass++;
   endtask

   task automatic test_unit_x();
      int lat, elat; logic bs, err, dn, eerr; logic [31:0] ppm, eppm; logic [39:0] mf, mp, emf, emp;
      model(32'd2_577_137, 32'd2_577_137, 40'd1_000_000_000, eerr, eppm, emf, emp, elat);
      do_job(32'd2_577_137, 32'd2_577_137, 40'd1_000_000_000, lat, bs, err, ppm, mf, mp, dn);
      n_checks++; if (ppm < 367_877 || ppm > 367_881) $display("FAIL e_ppm_tol: got %0d expected 367879+/-2", ppm); else n_pass++;
      n_checks++; if (mf < 40'd367_878_441 || mf > 40'd367_880_441) $display("FAIL e_mf_tol: got %0d expected 367879441+/-1000", mf); else n_pass++;
      n_checks++; if (mp !== 40'd1_000_000_000 - mf) $display("FAIL e_mp_sum: got %0d expected %0d", mp, 40'd1_000_000_000 - mf); else n_pass++;
      n_checks++; if (ppm !== eppm || mf !== emf) $display("FAIL e_model: got %0d/%0d expected %0d/%0d", ppm, mf, eppm, emf); else n_pass++;
      n_checks++; if (lat != elat) $display("FAIL e_latency: got %0d expected %0d", lat, elat); else n_pass++;
   endtask

   task automatic test_saturn();
      int lat, elat; logic bs, err, dn, eerr; logic [31:0] ppm, eppm; logic [39:0] mf, mp, emf, emp;
      model(32'd2_649_730, 32'd2_577_137, 40'd3_233_500_000, eerr, eppm, emf, emp, elat);
      do_job(32'd2_649_730, 32'd2_577_137, 40'd3_233_500_000, lat, bs, err, ppm, mf, mp, dn);
      n_checks++; if (ppm < 357_641 || ppm > 357_681) $display("FAIL sat_ppm_tol: got %0d expected 357661+/-20", ppm); else n_pass++;
      n_checks++; if (mp < 40'd2_076_792_300 || mp > 40'd2_077_207_700) $display("FAIL sat_mp_tol: got %0d expected 2077000000+/-0.01%%", mp); else n_pass++;
      n_checks++; if (ppm !== eppm || mf !== emf || mp !== emp) $display("FAIL sat_model: got %0d/%0d/%0d expected %0d/%0d/%0d", ppm, mf, mp, eppm, emf, emp); else n_pass++;
      n_checks++; if (lat != elat) $display("FAIL sat_latency: got %0d expected %0d", lat, elat); else n_pass++;
   endtask

   task automatic test_err();
      int lat, elat; logic bs, err, dn, eerr; logic [31:0] ppm, eppm; logic [39:0] mf, mp, emf, emp;
      logic [31:0] ve;
      ve = 32'd2_577_137;
      do_job(32'd1_000, 32'd0, 40'd5_000_000, lat, bs, err, ppm, mf, mp, dn);
      n_checks++; if (err !== 1'b1) $display("FAIL ve0_err: got %b expected 1", err); else n_pass++;
      n_checks++; if (lat != 2) $display("FAIL ve0_latency: got %0d expected 2", lat); else n_pass++;
      n_checks++; if (ppm !== 0 || mf !== 0 || mp !== 0) $display("FAIL ve0_outputs: got %0d/%0d/%0d expected 0/0/0", ppm, mf, mp); else n_pass++;
      n_checks++; if (dn !== 1'b0) $display("FAIL ve0_done_pulse: got %b expected 0", dn); else n_pass++;
      do_job(8 * ve, ve, 40'd5_000_000, lat, bs, err, ppm, mf, mp, dn);
      n_checks++; if (err !== 1'b1 || lat != 2) $display("FAIL x8_err: got err %b lat %0d expected 1/2", err, lat); else n_pass++;
      model(8 * ve - 1000, ve, 40'd5_000_000, eerr, eppm, emf, emp, elat);
      do_job(8 * ve - 1000, ve, 40'd5_000_000, lat, bs, err, ppm, mf, mp, dn);
      n_checks++; if (err !== 1'b0) $display("FAIL xmax_err: got %b expected 0", err); else n_pass++;
      n_checks++; if (ppm < 333 || ppm > 337) $display("FAIL xmax_ppm_tol: got %0d expected 335+/-2", ppm); else n_pass++;
      n_checks++; if (ppm !== eppm || mf !== emf || lat != elat) $display("FAIL xmax_model: got %0d/%0d/%0d expected %0d/%0d/%0d", ppm, mf, lat, eppm, emf, elat); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int lat_a, lat_b, la, lb; logic ea, eb; logic [31:0] pa, pb; logic [39:0] fa, fb, qa, qb;
      model(32'd2_577_137, 32'd2_577_137, 40'd1_000_000_000, ea, pa, fa, qa, lat_a);
      model(32'd1_000_000, 32'd3_000_000, 40'd500_000_000, eb, pb, fb, qb, lat_b);
      bus.dv = 32'd2_577_137; bus.ve = 32'd2_577_137; bus.m0 = 40'd1_000_000_000; bus.start = 1'b1;
      step();
      // start stays high and the inputs now carry job B while A is in flight
      bus.dv = 32'd1_000_000; bus.ve = 32'd3_000_000; bus.m0 = 40'd500_000_000;
      la = 1;
      while (bus.done !== 1'b1 && la < 200) begin step(); la++; end
      n_checks++; if (la != lat_a) $display("FAIL b2b_a_latency: got %0d expected %0d", la, lat_a); else n_pass++;
      n_checks++; if (bus.mu_ppm !== pa || bus.mf !== fa) $display("FAIL b2b_a_result: got %0d/%0d expected %0d/%0d", bus.mu_ppm, bus.mf, pa, fa); else n_pass++;
      step();
      n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL b2b_idle_gap: got done %b busy %b expected 0/0", bus.done, bus.busy); else n_pass++;
      step();
      bus.start = 1'b0;
      n_checks++; if (bus.busy !== 1'b1) $display("FAIL b2b_b_accept: got busy %b expected 1", bus.busy); else n_pass++;
      lb = 1;
      while (bus.done !== 1'b1 && lb < 200) begin step(); lb++; end
      n_checks++; if (lb != lat_b) $display("FAIL b2b_b_latency: got %0d expected %0d", lb, lat_b); else n_pass++;
      n_checks++; if (bus.mu_ppm !== pb || bus.mf !== fb || bus.mp !== qb) $display("FAIL b2b_b_result: got %0d/%0d/%0d expected %0d/%0d/%0d", bus.mu_ppm, bus.mf, bus.mp, pb, fb, qb); else n_pass++;
      step();
   endtask

   task automatic test_reset_mid();
      int lat, elat, seen; logic bs, err, dn, eerr; logic [31:0] ppm, eppm; logic [39:0] mf, mp, emf, emp;
      bus.dv = 32'd2_649_730; bus.ve = 32'd2_577_137; bus.m0 = 40'd3_233_500_000; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (11) step();   // 10 cycles into DIVX
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL abort_flags: got busy %b done %b expected 0/0", bus.busy, bus.done); else n_pass++;
      n_checks++; if (bus.mu_ppm !== 0 || bus.mf !== 0 || bus.mp !== 0 || bus.err !== 1'b0) $display("FAIL abort_outputs: got %0d/%0d/%0d err %b expected zeros", bus.mu_ppm, bus.mf, bus.mp, bus.err); else n_pass++;
      seen = 0;
      for (int i = 0; i < 80; i++) begin step(); if (bus.done === 1'b1 || bus.busy === 1'b1) seen++; end
      n_checks++; if (seen != 0) $display("FAIL abort_stays_idle: got %0d active cycles expected 0", seen); else n_pass++;
      model(32'd1_234_567, 32'd3_100_000, 40'd777_000_000, eerr, eppm, emf, emp, elat);
      do_job(32'd1_234_567, 32'd3_100_000, 40'd777_000_000, lat, bs, err, ppm, mf, mp, dn);
      n_checks++; if (err !== 1'b0 || ppm !== eppm || mf !== emf || mp !== emp || lat != elat) $display("FAIL abort_fresh_job: got %b/%0d/%0d/%0d/%0d expected 0/%0d/%0d/%0d/%0d", err, ppm, mf, mp, lat, eppm, emf, emp, elat); else n_pass++;
   endtask

   task automatic test_random();
      int lat, elat; logic bs, err, dn, eerr; logic [31:0] ppm, eppm, dv, ve; logic [39:0] m0, mf, mp, emf, emp;
      for (int i = 0; i < 12; i++) begin
         ve = (i % 6 == 5) ? 32'd0 : 32'($urandom_range(1000, 5_000_000));
         dv = (ve == 0) ? 32'($urandom) : 32'($urandom_range(0, 9 * ve));
         m0 = 40'({$urandom, $urandom});
         model(dv, ve, m0, eerr, eppm, emf, emp, elat);
         do_job(dv, ve, m0, lat, bs, err, ppm, mf, mp, dn);
         n_checks++; if (err !== eerr) $display("FAIL rand_err[%0d]: got %b expected %b", i, err, eerr); else n_pass++;
         n_checks++; if (ppm !== eppm) $display("FAIL rand_ppm[%0d]: got %0d expected %0d", i, ppm, eppm); else n_pass++;
         n_checks++; if (mf !== emf) $display("FAIL rand_mf[%0d]: got %0d expected %0d", i, mf, emf); else n_pass++;
         n_checks++; if (mp !== emp) $display("FAIL rand_mp[%0d]: got %0d expected %0d", i, mp, emp); else n_pass++;
         n_checks++; if (lat != elat || dn !== 1'b0) $display("FAIL rand_latency[%0d]: got %0d pulse-after %b expected %0d/0", i, lat, dn, elat); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_unit_x();
      test_saturn();
      test_err();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
